// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking occupancy controller.
package parking_pkg;

   localparam int REJ_W     = 8;
   localparam int MAX_LANES = 8;
   localparam int CNT_W     = 4;

   // Narrower lane vectors are zero-padded up to MAX_LANES by the caller.
   function automatic logic [CNT_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_LANES; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   function automatic logic [REJ_W-1:0] sat_add_rej(input logic [REJ_W-1:0] a,
                                                    input logic [CNT_W-1:0] b);
      logic [REJ_W:0] s;
      s = {1'b0, a} + (REJ_W+1)'(b);
      return s[REJ_W] ? '1 : s[REJ_W-1:0];
   endfunction

   function automatic logic [REJ_W-1:0] sat_sub_rej(input logic [REJ_W-1:0] a,
                                                    input logic [CNT_W-1:0] b);
      logic [REJ_W-1:0] bw;
      bw = REJ_W'(b);
      return (bw > a) ? '0 : a - bw;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; one pulse per 0->1.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic s_p0, s_p1, prev_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_p0    <= 1'b0;
         s_p1    <= 1'b0;
         prev_p2 <= 1'b0;
      end else begin
         s_p0    <= d;
         s_p1    <= s_p0;
         prev_p2 <= s_p1;
      end
   end

   // p1 -> p2 boundary: event when the synchronised level has just risen
   assign pulse = s_p1 & ~prev_p2;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-lane occupancy counter: exits applied before entries, clamped to 0..CAPACITY,
// with sticky over/underflow flags and a saturating reject counter.
module parking_occupancy_ctrl
   import parking_pkg::*;
#(
   parameter  int LANES    = 2,
   parameter  int CAPACITY = 7,
   localparam int CW       = $clog2(CAPACITY + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LANES-1:0] entry_sens,
   input  logic [LANES-1:0] exit_sens,
   input  logic             clear,
   output logic [CW-1:0]    occupancy,
   output logic [CW-1:0]    free_spots,
   output logic             full,
   output logic             empty,
   output logic             entry_ok,
   output logic             err_overflow,
   output logic             err_underflow,
   output logic [REJ_W-1:0] reject_cnt
);

   // Wide enough for occupancy headroom and for a full lane count.
   localparam int AW = (CW + 1 > CNT_W) ? CW + 1 : CNT_W;
   localparam logic [AW-1:0] CAP_W = AW'(CAPACITY);

   function automatic logic [AW-1:0] sub_floor0(input logic [AW-1:0] a,
                                                input logic [AW-1:0] b);
      return (b > a) ? '0 : a - b;
   endfunction

   function automatic logic [AW-1:0] min_w(input logic [AW-1:0] a,
                                           input logic [AW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   logic [LANES-1:0]     ent_ev, ext_ev;
   logic [MAX_LANES-1:0] ent_pad, ext_pad;
   logic [AW-1:0]        e_w, x_w, occ_w, occ1, acc, rej, occ_nx;
   logic                 udf_ev;
   logic [CNT_W-1:0]     rej_n;

   logic [CW-1:0]        occ_q;
   logic                 ovf_q, udf_q;
   logic [REJ_W-1:0]     rej_q;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      edge_sync u_ent (.clk(clk), .rst(rst), .d(entry_sens[g]), .pulse(ent_ev[g]));
      edge_sync u_ext (.clk(clk), .rst(rst), .d(exit_sens[g]),  .pulse(ext_ev[g]));
   end

   always_comb begin
      ent_pad            = '0;
      ext_pad            = '0;
      ent_pad[LANES-1:0] = ent_ev;
      ext_pad[LANES-1:0] = ext_ev;
      e_w    = AW'(popcount(ent_pad));
      x_w    = AW'(popcount(ext_pad));
      occ_w  = AW'(occ_q);
      udf_ev = x_w > occ_w;
      occ1   = sub_floor0(occ_w, x_w);
      acc    = min_w(e_w, CAP_W - occ1);
      rej    = e_w - acc;
      occ_nx = occ1 + acc;
      rej_n  = CNT_W'(rej);
   end

   // Edge events -> registered occupancy, flags and reject count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
         rej_q <= '0;
      end else if (clear) begin
         occ_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
         rej_q <= '0;
      end else begin
         occ_q <= CW'(occ_nx);
         if (udf_ev) udf_q <= 1'b1;
         if (rej_n != '0) begin
            ovf_q <= 1'b1;
            rej_q <= sat_add_rej(rej_q, rej_n);
         end
      end
   end

   assign occupancy     = occ_q;
   assign free_spots    = CW'(CAPACITY) - occ_q;
   assign full          = (occ_q == CW'(CAPACITY));
   assign empty         = (occ_q == '0);
   assign entry_ok      = ~full;
   assign err_overflow  = ovf_q;
   assign err_underflow = udf_q;
   assign reject_cnt    = rej_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl (LANES=2, CAPACITY=7).
module tb_parking_occupancy_ctrl;

   localparam int LANES    = 2;
   localparam int CAPACITY = 7;
   localparam int CW       = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [LANES-1:0] entry_sens = '0;
   logic [LANES-1:0] exit_sens  = '0;
   logic             clear = 1'b0;
   logic [CW-1:0]    occupancy, free_spots;
   logic             full, empty, entry_ok, err_overflow, err_underflow;
   logic [7:0]       reject_cnt;

   parking_occupancy_ctrl #(.LANES(LANES), .CAPACITY(CAPACITY)) dut (
      .clk(clk), .rst(rst), .entry_sens(entry_sens), .exit_sens(exit_sens),
      .clear(clear), .occupancy(occupancy), .free_spots(free_spots),
      .full(full), .empty(empty), .entry_ok(entry_ok),
      .err_overflow(err_overflow), .err_underflow(err_underflow),
      .reject_cnt(reject_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string name;
      int    due;
      int    occ;
      bit    ovf;
      bit    udf;
      int    rej;
   } exp_t;

   exp_t sbq[$];
   exp_t me;
   int   tests = 0;
   int   fails = 0;
   bit   ok;

   task automatic expect_at(input string name, input int due, input int occ,
                            input bit ovf, input bit udf, input int rej);
      exp_t e;
      e.name = name; e.due = due; e.occ = occ;
      e.ovf = ovf; e.udf = udf; e.rej = rej;
      sbq.push_back(e);
   endtask

   // Monitor: compares the full output bundle on the falling edge when an entry is due
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
         me = sbq.pop_front();
         tests++; fails++;
         $display("FAIL %s: check missed (due cycle %0d, now %0d)", me.name, me.due, cyc);
      end
      while (sbq.size() > 0 && sbq[0].due == cyc) begin
         me = sbq.pop_front();
         tests++;
         ok = (int'(occupancy) == me.occ) &&
              (int'(free_spots) == CAPACITY - me.occ) &&
              (full == (me.occ == CAPACITY)) &&
              (empty == (me.occ == 0)) &&
              (entry_ok == (me.occ != CAPACITY)) &&
              (err_overflow == me.ovf) && (err_underflow == me.udf) &&
              (int'(reject_cnt) == me.rej);
         if (!ok) begin
            fails++;
            $display("FAIL %s: got occ=%0d free=%0d full=%0b empty=%0b ok=%0b ovf=%0b udf=%0b rej=%0d, want occ=%0d free=%0d ovf=%0b udf=%0b rej=%0d",
                     me.name, occupancy, free_spots, full, empty, entry_ok,
                     err_overflow, err_underflow, reject_cnt,
                     me.occ, CAPACITY - me.occ, me.ovf, me.udf, me.rej);
         end
      end
   end

   // Two-cycle sensor pulse; result expected at the third edge after it rises.
   task automatic pulse(input string name, input logic [1:0] ent, input logic [1:0] ext,
                        input bit chk, input int occ, input bit ovf, input bit udf,
                        input int rej);
      @(posedge clk); #1;
      if (chk) expect_at(name, cyc + 3, occ, ovf, udf, rej);
      entry_sens = ent;
      exit_sens  = ext;
      repeat (2) @(posedge clk);
      #1;
      entry_sens = '0;
      exit_sens  = '0;
      @(posedge clk);
   endtask

   task automatic do_clear(input string name);
      @(posedge clk); #1;
      expect_at(name, cyc + 1, 0, 1'b0, 1'b0, 0);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   int c;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      expect_at("reset_state", cyc, 0, 1'b0, 1'b0, 0);
      tests++;
      if (occupancy !== 3'd0 || free_spots !== 3'd7 || empty !== 1'b1 ||
          full !== 1'b0 || entry_ok !== 1'b1 || err_overflow !== 1'b0 ||
          err_underflow !== 1'b0 || reject_cnt !== 8'd0) begin
         fails++;
         $display("FAIL reset_direct: occ=%0d free=%0d full=%0b empty=%0b ok=%0b ovf=%0b udf=%0b rej=%0d",
                  occupancy, free_spots, full, empty, entry_ok,
                  err_overflow, err_underflow, reject_cnt);
      end
      @(posedge clk); #2;
      rst = 1'b0;

      for (int i = 1; i <= 7; i++) pulse($sformatf("fill_%0d", i), 2'b01, 2'b00, 1'b1, i, 1'b0, 1'b0, 0);
      pulse("overflow_at_full", 2'b01, 2'b00, 1'b1, 7, 1'b1, 1'b0, 1);
      do_clear("clear_all");
      pulse("underflow_at_zero", 2'b00, 2'b01, 1'b1, 0, 1'b0, 1'b1, 0);
      do_clear("clear_udf");

      pulse("dual_2", 2'b11, 2'b00, 1'b1, 2, 1'b0, 1'b0, 0);
      pulse("dual_4", 2'b11, 2'b00, 1'b1, 4, 1'b0, 1'b0, 0);
      pulse("dual_6", 2'b11, 2'b00, 1'b1, 6, 1'b0, 1'b0, 0);
      pulse("dual_at_6", 2'b11, 2'b00, 1'b1, 7, 1'b1, 1'b0, 1);
      do_clear("clear_2");

      pulse("refill_2", 2'b11, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0);
      pulse("refill_4", 2'b11, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0);
      pulse("refill_6", 2'b11, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0);
      pulse("refill_7", 2'b01, 2'b00, 1'b1, 7, 1'b0, 1'b0, 0);
      pulse("swap_at_full", 2'b10, 2'b01, 1'b1, 7, 1'b0, 1'b0, 0);
      pulse("exit_to_6", 2'b00, 2'b01, 1'b1, 6, 1'b0, 1'b0, 0);

      // Held-high sensor: one event, landing exactly at the third edge
      @(posedge clk); #1;
      c = cyc;
      expect_at("held_edge_k1", c + 2, 6, 1'b0, 1'b0, 0);
      expect_at("held_edge_k2", c + 3, 7, 1'b0, 1'b0, 0);
      expect_at("held_20", c + 21, 7, 1'b0, 1'b0, 0);
      entry_sens = 2'b01;
      repeat (20) @(posedge clk);
      #1;
      entry_sens = '0;
      repeat (2) @(posedge clk);

      pulse("exit_to_6b", 2'b00, 2'b01, 1'b1, 6, 1'b0, 1'b0, 0);

      // Glitch entirely between edges: never sampled
      @(posedge clk); #2;
      expect_at("glitch_no_edge", cyc + 3, 6, 1'b0, 1'b0, 0);
      entry_sens = 2'b01;
      #2;
      entry_sens = '0;
      repeat (3) @(posedge clk);

      // One-period glitch straddling one edge: sampled once
      @(posedge clk); #6;
      expect_at("glitch_one_edge", cyc + 3, 7, 1'b0, 1'b0, 0);
      entry_sens = 2'b01;
      @(posedge clk); #6;
      entry_sens = '0;
      repeat (4) @(posedge clk);

      // Reject counter saturation at 255 (two rejects per pulse while full)
      for (int i = 1; i <= 130; i++) begin
         if (i == 127)      pulse("rej_254", 2'b11, 2'b00, 1'b1, 7, 1'b1, 1'b0, 254);
         else if (i == 128) pulse("rej_sat", 2'b11, 2'b00, 1'b1, 7, 1'b1, 1'b0, 255);
         else if (i == 130) pulse("rej_hold", 2'b11, 2'b00, 1'b1, 7, 1'b1, 1'b0, 255);
         else               pulse("rej_run", 2'b11, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0);
      end
      do_clear("clear_3");

      pulse("pre_rst_2", 2'b11, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0);
      pulse("pre_rst_4", 2'b11, 2'b00, 1'b1, 4, 1'b0, 1'b0, 0);

      // Asynchronous reset with sensors held high, then one event per lane after release
      @(posedge clk); #1;
      entry_sens = 2'b11;
      @(posedge clk); #2;
      rst = 1'b1;
      expect_at("rst_async", cyc, 0, 1'b0, 1'b0, 0);
      #1;
      tests++;
      if (occupancy !== 3'd0 || free_spots !== 3'd7 || empty !== 1'b1 ||
          full !== 1'b0 || entry_ok !== 1'b1 || err_overflow !== 1'b0 ||
          err_underflow !== 1'b0 || reject_cnt !== 8'd0) begin
         fails++;
         $display("FAIL rst_immediate: occ=%0d free=%0d full=%0b empty=%0b ok=%0b ovf=%0b udf=%0b rej=%0d",
                  occupancy, free_spots, full, empty, entry_ok,
                  err_overflow, err_underflow, reject_cnt);
      end
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      expect_at("rst_rearm", cyc + 3, 2, 1'b0, 1'b0, 0);
      expect_at("rst_once", cyc + 8, 2, 1'b0, 1'b0, 0);
      repeat (9) @(posedge clk);
      entry_sens = '0;

      for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
      while (sbq.size() > 0) begin
         me = sbq.pop_front();
         tests++; fails++;
         $display("FAIL %s: never checked (due cycle %0d)", me.name, me.due);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, now cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
